vga_line_buffer: RTL and testbench



---
 rtl/vga_line_buffer.sv | 151 +++++++++++++++
 tb/tb_vga_line_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_line_buffer.sv
// Tiled pixel source: a single-port frame buffer RAM refills two ping-pong line
// buffers one tile row ahead of the scan; the pixel is looked up combinationally.
module vga_line_buffer #(
   parameter  int WIDTH_PX          = 640,
   parameter  int HEIGHT_LNS        = 480,
   parameter  int H_B_PORCH_MAX_PX  = 144,
   parameter  int V_B_PORCH_MAX_LNS = 35,
   parameter  int TILE_WIDTH        = 4,
   parameter  int PXL_WIDTH         = 12,
   parameter  int TILE_PER_ROW      = 5,
   parameter  int PXL_CTR_WIDTH     = 10,
   parameter  int LN_CTR_WIDTH      = 10,
   localparam int TILE_PER_LINE     = WIDTH_PX / TILE_WIDTH,
   localparam int ROWS_PER_LINE     = TILE_PER_LINE / TILE_PER_ROW,
   localparam int TILE_LINES        = HEIGHT_LNS / TILE_WIDTH,
   localparam int FBUFF_DEPTH       = TILE_LINES * ROWS_PER_LINE,
   localparam int FBUFF_DATA_WIDTH  = TILE_PER_ROW * PXL_WIDTH,
   localparam int FBUFF_ADDR_WIDTH  = $clog2(FBUFF_DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [PXL_CTR_WIDTH-1:0]    pxl_cntr_i,
   input  logic [LN_CTR_WIDTH-1:0]     ln_cntr_i,
   input  logic                        fbuff_wen_i,
   input  logic [FBUFF_ADDR_WIDTH-1:0] fbuff_waddr_i,
   input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_wdata_i,
   output logic [PXL_WIDTH-1:0]        disp_pxl_o,
   output logic                        fill_busy_o
);

   localparam int TROW_W     = $clog2(TILE_LINES);
   localparam int TILE_W     = $clog2(TILE_PER_LINE);
   localparam int WORD_W     = $clog2(ROWS_PER_LINE);
   localparam int TILE_SHIFT = $clog2(TILE_WIDTH);

   typedef enum logic [1:0] {IDLE, READ, LAST} state_t;

   state_t                      state_q, state_d;
   logic [WORD_W-1:0]           word_q, word_d;
   logic [FBUFF_ADDR_WIDTH-1:0] base_q, base_d;
   logic                        buf_q, buf_d;
   logic                        rd_vld_q;
   logic [WORD_W-1:0]           rd_word_q;
   logic                        rd_buf_q;
   logic [FBUFF_DATA_WIDTH-1:0] rdata_q;
   logic                        rd_en;

   logic [FBUFF_DATA_WIDTH-1:0] fbuff_mem [FBUFF_DEPTH];
   logic [PXL_WIDTH-1:0]        lbuf_q [2][TILE_PER_LINE];

   logic                        act_v, act_h;
   logic [LN_CTR_WIDTH-1:0]     dline;
   logic [PXL_CTR_WIDTH-1:0]    pxl_off;
   logic [TROW_W-1:0]           trow, req_row;
   logic [TILE_W-1:0]           tile;
   logic                        req_pre, req_ahead, req;
   logic [FBUFF_ADDR_WIDTH-1:0] rd_addr, ram_addr;

   assign act_v   = (ln_cntr_i >= LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS)) &&
                    (ln_cntr_i <  LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS + HEIGHT_LNS));
   assign act_h   = (pxl_cntr_i >= PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX)) &&
                    (pxl_cntr_i <  PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX + WIDTH_PX));
   assign dline   = ln_cntr_i - LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
   assign pxl_off = pxl_cntr_i - PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
   assign trow    = TROW_W'(dline >> TILE_SHIFT);
   assign tile    = TILE_W'(pxl_off >> TILE_SHIFT);

   always_comb begin
      disp_pxl_o = '0;
      if (act_v && act_h)
         disp_pxl_o = lbuf_q[trow[0]][tile];
   end

   // Refill requests: row 0 the line before the frame, row r+1 on the first line of row r.
   assign req_pre   = (ln_cntr_i == LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS - 1));
   assign req_ahead = act_v && (dline[TILE_SHIFT-1:0] == '0) &&
                      (trow < TROW_W'(TILE_LINES - 1));
   assign req       = (pxl_cntr_i == '0) && (req_pre || req_ahead);
   assign req_row   = req_pre ? '0 : trow + TROW_W'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         word_q    <= '0;
         base_q    <= '0;
         buf_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_word_q <= '0;
         rd_buf_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         base_q    <= base_d;
         buf_q     <= buf_d;
         rd_vld_q  <= rd_en;
         rd_word_q <= word_q;
         rd_buf_q  <= buf_q;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      base_d  = base_q;
      buf_d   = buf_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = READ;
               word_d  = '0;
               base_d  = FBUFF_ADDR_WIDTH'(req_row) * FBUFF_ADDR_WIDTH'(ROWS_PER_LINE);
               buf_d   = req_row[0];
            end
         end
         READ: begin
            if (rd_en) begin
               word_d = word_q + WORD_W'(1);
               if (word_q == WORD_W'(ROWS_PER_LINE - 1))
                  state_d = LAST;
            end
         end
         LAST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An external write steals the single RAM port; the fill read waits a cycle.
   always_comb begin
      fill_busy_o = (state_q != IDLE);
      rd_en       = (state_q == READ) && !fbuff_wen_i;
   end

   assign rd_addr  = base_q + FBUFF_ADDR_WIDTH'(word_q);
   assign ram_addr = fbuff_wen_i ? fbuff_waddr_i : rd_addr;

   always_ff @(posedge clk_i) begin
      if (fbuff_wen_i)
         fbuff_mem[ram_addr] <= fbuff_wdata_i;
      else if (rd_en)
         rdata_q <= fbuff_mem[ram_addr];
   end

   always_ff @(posedge clk_i) begin
      if (rd_vld_q) begin
         for (int t = 0; t < TILE_PER_ROW; t++)
            lbuf_q[rd_buf_q][TILE_W'(rd_word_q) * TILE_W'(TILE_PER_ROW) + TILE_W'(t)]
               <= rdata_q[t*PXL_WIDTH +: PXL_WIDTH];
      end
   end

endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed bench for vga_line_buffer: counters are driven directly, expected pixels
// come from a tile-pattern model and flow through a scoreboard queue.
module tb_vga_line_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  pxl, ln;
   logic        wen;
   logic [11:0] waddr;
   logic [59:0] wdata;
   logic [11:0] disp;
   logic        busy;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [11:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   vga_line_buffer dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .pxl_cntr_i   (pxl),
      .ln_cntr_i    (ln),
      .fbuff_wen_i  (wen),
      .fbuff_waddr_i(waddr),
      .fbuff_wdata_i(wdata),
      .disp_pxl_o   (disp),
      .fill_busy_o  (busy)
   );

   // Even rows count up across the line, odd rows count down.
   function automatic logic [11:0] pix(int r, int t);
      int v;
      v = ((r % 2 == 0) ? t : 159 - t) * 'h111 + r * 'h010;
      return v[11:0];
   endfunction

   function automatic logic [59:0] word_of(int r, int w);
      logic [59:0] d;
      for (int k = 0; k < 5; k++) d[k*12 +: 12] = pix(r, w*5 + k);
      return d;
   endfunction

   task automatic check(string tag, int obs, int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive counters, queue the expected pixel, compare on the falling edge.
   task automatic disp_chk(int l, int p, logic [11:0] e, string tag);
      logic [11:0] ev;
      string       tg;
      @(posedge clk); #1;
      ln  = 10'(l);
      pxl = 10'(p);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      ev = exp_q.pop_front();
      tg = tag_q.pop_front();
      check(tg, int'(disp), int'(ev));
   endtask

   // Request a fill at (l, pxl 0), then count busy cycles; optionally stall once.
   task automatic fill(int l, int exp_cycles, bit stall, string tag);
      int cnt;
      @(posedge clk); #1;
      ln  = 10'(l);
      pxl = 10'd0;
      @(posedge clk); #1;
      pxl = 10'd1;
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (wen) wen = 1'b0;
         if (busy) cnt++;
         else if (cnt > 0) break;
         if (stall && cnt == 10) begin
            wen   = 1'b1;
            waddr = 12'(100*32);
            wdata = word_of(100, 0);
         end
      end
      wen = 1'b0;
      check(tag, cnt, exp_cycles);
   endtask

   initial begin
      rst   = 1'b1;
      pxl   = 10'd0;
      ln    = 10'd0;
      wen   = 1'b0;
      waddr = '0;
      wdata = '0;
      @(negedge clk);
      check("rst_disp", int'(disp), 0);
      check("rst_busy", int'(busy), 0);

      // Load the whole frame while held in reset
      for (int r = 0; r < 120; r++)
         for (int w = 0; w < 32; w++) begin
            @(posedge clk); #1;
            wen   = 1'b1;
            waddr = 12'(r*32 + w);
            wdata = word_of(r, w);
         end
      @(posedge clk); #1;
      wen = 1'b0;
      @(negedge clk);
      check("rst_busy_after_writes", int'(busy), 0);
      @(posedge clk); #1;
      ln  = 10'd2;
      pxl = 10'd5;
      rst = 1'b0;

      fill(34, 33, 1'b0, "prefill_len");
      disp_chk(34, 200, 12'h000, "blank_line34");
      disp_chk(35, 143, 12'h000, "blank_pxl143");
      disp_chk(35, 784, 12'h000, "blank_pxl784");
      disp_chk(515, 200, 12'h000, "blank_line515");
      disp_chk(35, 144, 12'h000, "l35_p144");
      disp_chk(35, 147, 12'h000, "l35_p147");
      disp_chk(35, 148, 12'h111, "l35_p148");
      disp_chk(35, 783, pix(0, 159), "l35_p783");

      fill(35, 34, 1'b1, "ahead_fill_stall_len");
      disp_chk(38, 148, pix(0, 1), "l38_row0");
      disp_chk(39, 144, pix(1, 0), "l39_row1_first");
      disp_chk(39, 783, pix(1, 159), "l39_row1_last");
      for (int t = 0; t < 160; t++) disp_chk(40, 144 + 4*t, pix(1, t), "row1_sweep");

      // Abort a fill of row 2 (targets buffer 0) with reset, then prefill again
      @(posedge clk); #1;
      ln  = 10'd39;
      pxl = 10'd0;
      @(posedge clk); #1;
      pxl = 10'd1;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midfill_rst_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("after_rst_busy", int'(busy), 0);
      fill(34, 33, 1'b0, "prefill_after_rst_len");
      for (int t = 0; t < 160; t++) disp_chk(36, 144 + 4*t, pix(0, t), "row0_sweep");

      // Frame end and wrap to the next frame's prefill
      fill(507, 33, 1'b0, "fill_row119_len");
      disp_chk(511, 144, pix(119, 0), "l511_row119");
      disp_chk(514, 783, pix(119, 159), "l514_row119");
      disp_chk(512, 400, pix(119, 64), "l512_row119");
      @(posedge clk); #1;
      ln  = 10'd511;
      pxl = 10'd0;
      @(negedge clk);
      @(negedge clk);
      check("no_fill_after_row119", int'(busy), 0);
      fill(34, 33, 1'b0, "frame2_prefill_len");
      disp_chk(35, 148, pix(0, 1), "frame2_l35");
      disp_chk(35, 783, pix(0, 159), "frame2_l35_last");
      disp_chk(514, 200, pix(119, 14), "row119_kept");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
